// File: rtl/dflop_pkg.sv
// Shared definitions for the set/reset D flop: control-mode names and the
// decoder that maps the {set, reset} pair onto them.
package dflop_pkg;

   typedef enum logic [1:0] {
      HOLD_D  = 2'b00,
      FORCE0  = 2'b01,
      FORCE1  = 2'b10,
      COLLIDE = 2'b11
   } ctrl_mode_e;

   // Neither control outranks the other; both together release the output.
   function automatic ctrl_mode_e decode_ctrl(input logic set_i, input logic reset_i);
      ctrl_mode_e mode;
      unique case ({set_i, reset_i})
         2'b00:   mode = HOLD_D;
         2'b01:   mode = FORCE0;
         2'b10:   mode = FORCE1;
         default: mode = COLLIDE;
      endcase
      return mode;
   endfunction

endpackage

// File: rtl/dflop_clk_sr_if.sv
// Control/data bundle for dflop_clk_sr. Q stays outside the bundle as a plain
// tri-state net so the released state resolves on an ordinary wire.
interface dflop_clk_sr_if #(
   parameter int WIDTH = 1
);
   logic             set;
   logic             reset;
   logic [WIDTH-1:0] D;
   logic             conflict;

   modport master (output set, output reset, output D, input  conflict);
   modport slave  (input  set, input  reset, input  D, output conflict);
endinterface

// File: rtl/dflop_clk_sr_cell.sv
// One storage bit: a data register plus a drive-enable register feeding a
// tri-state output driver.
module dflop_sr_cell
   import dflop_pkg::*;
(
   input  logic       clk,
   input  ctrl_mode_e mode_i,
   input  logic       d_i,
   output tri         q_o
);

   logic data_q;
   logic data_d;
   logic en_q;
   logic en_d;

   always_comb begin
      data_d = d_i;
      en_d   = 1'b1;
      unique case (mode_i)
         FORCE0:  data_d = 1'b0;
         FORCE1:  data_d = 1'b1;
         // Collision clears the stored bit so recovery never exposes stale data.
         COLLIDE: begin
            data_d = 1'b0;
            en_d   = 1'b0;
         end
         default: data_d = d_i;
      endcase
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
      en_q   <= en_d;
   end

   assign q_o = en_q ? data_q : 1'bz;

endmodule

// File: rtl/dflop_clk_sr.sv
// WIDTH-bit D flop with shared synchronous set and reset; a set/reset collision
// tri-states Q and raises the registered conflict flag.
module dflop_clk_sr
   import dflop_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic [WIDTH-1:0] D,
   output tri   [WIDTH-1:0] Q,
   output logic             conflict
);

   ctrl_mode_e mode;
   logic       conflict_q;
   logic       conflict_d;

   always_comb begin
      mode       = decode_ctrl(set, reset);
      conflict_d = (mode == COLLIDE);
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         dflop_sr_cell u_cell (
            .clk    (clk),
            .mode_i (mode),
            .d_i    (D[gi]),
            .q_o    (Q[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      conflict_q <= conflict_d;
   end

   assign conflict = conflict_q;

endmodule

// File: tb/tb_dflop_clk_sr.sv
// Directed bench for dflop_clk_sr: a 1-bit and an 8-bit instance share the
// clock; outputs are sampled on the falling edge, 10 ns after each rising edge.
module tb_dflop_clk_sr;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   dflop_clk_sr_if #(.WIDTH(1)) bus1 ();
   dflop_clk_sr_if #(.WIDTH(8)) bus8 ();

   tri       q1;
   tri [7:0] q8;

   dflop_clk_sr #(.WIDTH(1)) dut1 (
      .clk      (clk),
      .reset    (bus1.reset),
      .set      (bus1.set),
      .D        (bus1.D),
      .Q        (q1),
      .conflict (bus1.conflict)
   );

   dflop_clk_sr #(.WIDTH(8)) dut8 (
      .clk      (clk),
      .reset    (bus8.reset),
      .set      (bus8.set),
      .D        (bus8.D),
      .Q        (q8),
      .conflict (bus8.conflict)
   );

   int errors = 0;
   int checks = 0;

   task automatic drive1(input logic s, input logic r, input logic d);
      bus1.set   = s;
      bus1.reset = r;
      bus1.D     = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive8(input logic s, input logic r, input logic [7:0] d);
      bus8.set   = s;
      bus8.reset = r;
      bus8.D     = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive1(1'b0, 1'b1, 1'b1);
      drive8(1'b0, 1'b1, 8'hFF);
      checks++;
      if (q1 !== 1'b0 || bus1.conflict !== 1'b0) begin
         errors++;
         $display("FAIL reset_w1: Q=%b conflict=%b expected Q=0 conflict=0", q1, bus1.conflict);
      end
      checks++;
      if (q8 !== 8'h00 || bus8.conflict !== 1'b0) begin
         errors++;
         $display("FAIL reset_w8: Q=%h conflict=%b expected Q=00 conflict=0", q8, bus8.conflict);
      end
      $display("reset: w1 Q=%b w8 Q=%h", q1, q8);
   endtask

   task automatic test_hold_d();
      logic exp_q;
      for (int i = 0; i < 2; i++) begin
         exp_q = (i == 1);
         drive1(1'b0, 1'b0, exp_q);
         checks++;
         if (q1 !== exp_q || bus1.conflict !== 1'b0) begin
            errors++;
            $display("FAIL hold_d_%0d: Q=%b conflict=%b expected Q=%b conflict=0",
                     i, q1, bus1.conflict, exp_q);
         end
         $display("hold_d: D=%b -> Q=%b conflict=%b", exp_q, q1, bus1.conflict);
      end
   endtask

   task automatic test_reset_over_d();
      for (int i = 0; i < 2; i++) begin
         drive1(1'b0, 1'b1, i[0]);
         checks++;
         if (q1 !== 1'b0 || bus1.conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_d_%0d: Q=%b conflict=%b expected Q=0 conflict=0",
                     i, q1, bus1.conflict);
         end
         $display("reset_over_d: D=%0d -> Q=%b", i, q1);
      end
   endtask

   task automatic test_set_over_d();
      for (int i = 0; i < 2; i++) begin
         drive1(1'b1, 1'b0, i[0]);
         checks++;
         if (q1 !== 1'b1 || bus1.conflict !== 1'b0) begin
            errors++;
            $display("FAIL set_over_d_%0d: Q=%b conflict=%b expected Q=1 conflict=0",
                     i, q1, bus1.conflict);
         end
         $display("set_over_d: D=%0d -> Q=%b", i, q1);
      end
   endtask

   task automatic test_collide();
      logic exp_z;
      exp_z = 1'bz;
      for (int i = 0; i < 2; i++) begin
         drive1(1'b1, 1'b1, i[0]);
         checks++;
         if (q1 !== exp_z || bus1.conflict !== 1'b1) begin
            errors++;
            $display("FAIL collide_%0d: Q=%b conflict=%b expected Q=z conflict=1",
                     i, q1, bus1.conflict);
         end
         $display("collide: D=%0d -> Q=%b conflict=%b", i, q1, bus1.conflict);
      end
   endtask

   task automatic test_recover_and_count();
      logic       exp_tbl [8];
      logic       exp_c;
      logic [2:0] v;
      exp_tbl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'bz, 1'bz};
      drive1(1'b0, 1'b0, 1'b0);
      checks++;
      if (q1 !== 1'b0 || bus1.conflict !== 1'b0) begin
         errors++;
         $display("FAIL recover: Q=%b conflict=%b expected Q=0 conflict=0", q1, bus1.conflict);
      end
      $display("recover: Q=%b conflict=%b", q1, bus1.conflict);
      for (int i = 0; i < 8; i++) begin
         v     = i[2:0];
         exp_c = (i >= 6);
         drive1(v[2], v[1], v[0]);
         checks++;
         if (q1 !== exp_tbl[i] || bus1.conflict !== exp_c) begin
            errors++;
            $display("FAIL count_%0d: Q=%b conflict=%b expected Q=%b conflict=%b",
                     i, q1, bus1.conflict, exp_tbl[i], exp_c);
         end
         $display("count: {set,reset,D}=%b -> Q=%b conflict=%b", v, q1, bus1.conflict);
      end
   endtask

   task automatic test_wide();
      drive8(1'b0, 1'b0, 8'hA5);
      checks++;
      if (q8 !== 8'hA5) begin
         errors++;
         $display("FAIL wide_d: Q=%h expected a5", q8);
      end
      $display("wide: D=a5 -> Q=%h", q8);
      drive8(1'b1, 1'b0, 8'h12);
      checks++;
      if (q8 !== 8'hFF) begin
         errors++;
         $display("FAIL wide_set: Q=%h expected ff", q8);
      end
      $display("wide: set -> Q=%h", q8);
      drive8(1'b0, 1'b1, 8'h34);
      checks++;
      if (q8 !== 8'h00) begin
         errors++;
         $display("FAIL wide_reset: Q=%h expected 00", q8);
      end
      $display("wide: reset -> Q=%h", q8);
      drive8(1'b0, 1'b0, 8'h3C);
      bus8.D = 8'hC3;
      #5;
      checks++;
      if (q8 !== 8'h3C) begin
         errors++;
         $display("FAIL wide_midcycle: Q=%h expected 3c", q8);
      end
      $display("wide: D toggled mid-cycle -> Q=%h", q8);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (q8 !== 8'hC3) begin
         errors++;
         $display("FAIL wide_next_edge: Q=%h expected c3", q8);
      end
      $display("wide: next edge -> Q=%h", q8);
   endtask

   task automatic test_wide_collide();
      logic [7:0] exp_z;
      exp_z = 8'hzz;
      drive8(1'b1, 1'b1, 8'h5A);
      checks++;
      if (q8 !== exp_z || bus8.conflict !== 1'b1) begin
         errors++;
         $display("FAIL wide_collide: Q=%h conflict=%b expected Q=zz conflict=1",
                  q8, bus8.conflict);
      end
      $display("wide_collide: Q=%h conflict=%b", q8, bus8.conflict);
      drive8(1'b1, 1'b0, 8'h00);
      checks++;
      if (q8 !== 8'hFF || bus8.conflict !== 1'b0) begin
         errors++;
         $display("FAIL wide_recover_set: Q=%h conflict=%b expected Q=ff conflict=0",
                  q8, bus8.conflict);
      end
      $display("wide_recover_set: Q=%h conflict=%b", q8, bus8.conflict);
   endtask

   initial begin
      bus1.set = 1'b0; bus1.reset = 1'b0; bus1.D = 1'b0;
      bus8.set = 1'b0; bus8.reset = 1'b0; bus8.D = 8'h00;
      @(negedge clk);
      test_reset();
      test_hold_d();
      test_reset_over_d();
      test_set_over_d();
      test_collide();
      test_recover_and_count();
      test_wide();
      test_wide_collide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
